avalon_st_packet_generator: RTL and testbench
=============================================

# avalon_st_packet_generator

Trusted Avalon-ST source that builds complete, protocol-correct packets from a single start command. Drives the master side of an `avalon_st_if`, so it is the transmitting end of the streams our enforcer and sink blocks consume. Used as a traffic source in integration benches and as the packet emitter in self-test paths. Length, byte pattern and inter-packet gap are set per packet.

## Interface
Parameters:
- `DATA_WIDTH_IN_BYTES`, default 16: bytes per beat (W). Must be a power of two, ≥ 2.
- `LEN_WIDTH`, default 16: width of the packet length in bytes.
- `GAP_WIDTH`, default 8: width of the inter-packet gap count.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous reset, active-low.
- `start`, input, 1: request one packet. Sampled only in IDLE.
- `packet_len`, input, LEN_WIDTH: packet length in bytes. Latched on an accepted `start`.
- `seed`, input, 8: value of packet byte 0. Latched on an accepted `start`.
- `gap_cycles`, input, GAP_WIDTH: number of idle cycles after `eop`. Latched on an accepted `start`.
- `generated`, `avalon_st_if.master`, W bytes: `data` [8W-1:0], `valid`, `sop`, `eop`, `empty` [$clog2(W)-1:0]. Receives `rdy` from the sink.
- `busy`, output, 1: high in SEND and GAP.
- `done`, output, 1: one-cycle pulse after the `eop` beat is accepted.
- `len_error`, output, 1: one-cycle pulse when `start` is sampled with `packet_len == 0`.
- `packets_sent`, output, 16: count of completed packets. Wraps modulo 2^16.

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - `start=1` with `packet_len ≠ 0` latches the inputs, loads beat 0 onto the bus and moves to SEND.
  - `start=1` with `packet_len = 0` pulses `len_error` and stays in IDLE.
- Beats per packet: B = ceil(L/W), where L is the latched length. Beat index b runs from 0 to B-1.
- Byte pattern:
  - Packet byte k = (seed + k) mod 256, for k in 0..L-1.
  - Byte ordering is MSB-first: byte k of beat b sits at `data[8W-1-8j -: 8]`, where j = k - bW.
- Framing:
  - `sop` = 1 only on beat 0.
  - `eop` = 1 only on beat B-1. For L ≤ W, `sop` and `eop` are on the same beat.
  - `empty` = B·W - L on the `eop` beat, and 0 on every other beat.
  - Lanes covered by `empty` carry 0x00.
- Handshake:
  - A beat transfers on a clock edge where `valid && rdy`.
  - While `valid=1 && rdy=0`, `data`, `sop`, `eop` and `empty` are held unchanged.
  - `valid` never drops mid-packet, except on reset.
- SEND:
  - Each transfer advances b and loads the next beat.
  - Transfer of the `eop` beat: `valid` goes to 0 next cycle, `done` pulses, `packets_sent` increments.
  - Next state is GAP if the latched `gap_cycles > 0`, otherwise IDLE.
- GAP: counts down the latched `gap_cycles`, then enters IDLE. `start` is ignored here.
- `start` during SEND or GAP is ignored. It is not queued.
- Input changes after an accepted `start` have no effect on the current packet.
- All bus outputs are registered. No combinational path from `rdy` to any output.

## Timing
- Reset (`rst=0` at an edge), effective next cycle:
  - State goes to IDLE.
  - `valid`, `sop`, `eop`, `busy`, `done` and `len_error` go to 0.
  - `data`, `empty` and `packets_sent` go to 0.
  - Reset mid-packet abandons the packet with no `eop`. Downstream is expected to cope.
- Start latency: `start` sampled at edge N gives `valid=1`, `sop=1` and `busy=1` in the cycle after N.
- With `rdy` held at 1, `valid` is high for B consecutive cycles.
- `done` and `busy` relative to the `eop` transfer at edge M:
  - `done=1` in the cycle after M.
  - With `gap_cycles = G`, `busy` stays high for G further cycles, then the block is in IDLE.
  - With G = 0, `busy` drops in the cycle after M.
- Minimum spacing: the earliest next `start` is sampled in the first IDLE cycle. Back-to-back packets therefore have at least 1 idle cycle between `eop` and the next `sop`.
- `len_error` is asserted in the cycle after the `start` is sampled.

## Test plan
- **Multi-beat packet:** W=16, L=40, seed=0x10, `rdy`=1, G=0.
  - Expect 3 beats in consecutive cycles.
  - Beat 0: `sop`=1, bytes 0x10..0x1F, MSB lane first.
  - Beat 2: `eop`=1, `empty`=8, bytes 0x30..0x37 in the top 8 lanes, low 8 lanes zero.
  - `done` pulses once and `packets_sent`=1.
- **Single full beat:** L=16, seed=0x00.
  - One beat with `sop`=`eop`=1, `empty`=0, bytes 0x00..0x0F.
  - `busy` drops the cycle after the transfer.
- **Backpressure and byte wrap:** L=20, seed=0xF8, `rdy` pattern 1,0,0,1.
  - Beat 0 (0xF8..0xFF, 0x00..0x07) transfers.
  - Beat 1 then holds bit-stable for 2 cycles. It carries 0x08..0x0B, `empty`=12, `eop`=1.
  - Beat 1 transfers on the fourth edge.
- **Ignored and rejected starts:**
  - `start` pulsed during SEND and GAP: no extra packet, `packets_sent` unchanged.
  - `start` with L=0 in IDLE: `len_error` pulses for 1 cycle and `valid` stays 0.
- **Reset mid-packet:** L=48, reset asserted after beat 0 transfers.
  - All outputs are 0 in the cycle after reset; `packets_sent`=0.
  - A new `start` (L=16) yields a fresh `sop` beat.
- **Gap timing:** G=3, two packets each with L=16, `start` held at 1.
  - `busy` is high for 3 cycles after `done`.
  - The second `sop` appears exactly 5 cycles after the first `eop` cycle.

Source files
------------

// File: rtl/avalon_st_packet_generator_if.sv
// Avalon-ST bus bundle: one beat of W bytes with packet framing and ready backpressure.
// The interface is named avalon_st_if so the enforcer and sink blocks can share it.
interface avalon_st_if #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16
) ();
    localparam int unsigned EmptyWidth = $clog2(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EmptyWidth-1:0]            empty;
    logic                             rdy;

    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        output empty,
        input  rdy
    );

    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        input  empty,
        output rdy
    );
endinterface

// File: rtl/avalon_st_packet_generator.sv
// Avalon-ST packet source: one start command emits a framed packet of incrementing bytes,
// followed by a programmable idle gap. All bus outputs come straight from registers.
module avalon_st_packet_generator #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned LEN_WIDTH           = 16,
    parameter int unsigned GAP_WIDTH           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] packet_len,
    input  logic [7:0]           seed,
    input  logic [GAP_WIDTH-1:0] gap_cycles,
    avalon_st_if.master          generated,
    output logic                 busy,
    output logic                 done,
    output logic                 len_error,
    output logic [15:0]          packets_sent
);

    localparam int unsigned W  = DATA_WIDTH_IN_BYTES;
    localparam int unsigned EW = $clog2(W);
    localparam int unsigned DW = 8 * W;
    localparam logic [LEN_WIDTH-1:0] WLen = LEN_WIDTH'(W);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    // MSB-first lanes; lanes at or beyond the remaining byte count are zero-filled.
    function automatic logic [DW-1:0] beat_data(input logic [7:0] base,
                                                input logic [LEN_WIDTH-1:0] left);
        logic [DW-1:0] d;
        d = '0;
        for (int unsigned j = 0; j < W; j++) begin
            if (LEN_WIDTH'(j) < left) begin
                d[DW-1-8*j -: 8] = base + 8'(j);
            end
        end
        return d;
    endfunction

    state_e                 state_q, state_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [EW-1:0]          empty_q, empty_d;
    logic                   done_q, done_d;
    logic                   len_err_q, len_err_d;
    logic [15:0]            pkt_q, pkt_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    // Running byte value and remaining length for the beat after the one on the bus.
    logic [7:0]             next_base_q, next_base_d;
    logic [LEN_WIDTH-1:0]   next_left_q, next_left_d;

    logic                   load;
    logic [7:0]             load_base;
    logic [LEN_WIDTH-1:0]   load_left;
    logic                   load_last;

    assign load_base = (state_q == StIdle) ? seed : next_base_q;
    assign load_left = (state_q == StIdle) ? packet_len : next_left_q;
    assign load_last = (load_left <= WLen);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        empty_d     = empty_q;
        done_d      = 1'b0;
        len_err_d   = 1'b0;
        pkt_d       = pkt_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        next_base_d = next_base_q;
        next_left_d = next_left_q;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (packet_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d = StSend;
                        valid_d = 1'b1;
                        sop_d   = 1'b1;
                        gap_d   = gap_cycles;
                        load    = 1'b1;
                    end
                end
            end
            StSend: begin
                if (valid_q && generated.rdy) begin
                    if (eop_q) begin
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        data_d  = '0;
                        empty_d = '0;
                        done_d  = 1'b1;
                        pkt_d   = pkt_q + 16'd1;
                        if (gap_q != '0) begin
                            state_d   = StGap;
                            // The done cycle is the first of the gap cycles.
                            gap_cnt_d = gap_q - 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        sop_d = 1'b0;
                        load  = 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            data_d      = beat_data(load_base, load_left);
            eop_d       = load_last;
            empty_d     = load_last ? EW'(WLen - load_left) : '0;
            next_base_d = load_base + 8'(W);
            next_left_d = load_left - WLen;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            empty_q     <= '0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            pkt_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            next_base_q <= '0;
            next_left_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            empty_q     <= empty_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
            pkt_q       <= pkt_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            next_base_q <= next_base_d;
            next_left_q <= next_left_d;
        end
    end

    assign generated.data  = data_q;
    assign generated.valid = valid_q;
    assign generated.sop   = sop_q;
    assign generated.eop   = eop_q;
    assign generated.empty = empty_q;

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign len_error    = len_err_q;
    assign packets_sent = pkt_q;

endmodule

// File: tb/tb_avalon_st_packet_generator.sv
// Directed bench for avalon_st_packet_generator with W=16: framing, byte pattern,
// backpressure hold, ignored/rejected starts, mid-packet reset and gap spacing.
module tb_avalon_st_packet_generator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] packet_len;
    logic [7:0]  seed;
    logic [7:0]  gap_cycles;
    logic        busy;
    logic        done;
    logic        len_error;
    logic [15:0] packets_sent;

    int n_total;
    int n_pass;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) av ();

    avalon_st_packet_generator #(
        .DATA_WIDTH_IN_BYTES(16),
        .LEN_WIDTH(16),
        .GAP_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .packet_len(packet_len),
        .seed(seed),
        .gap_cycles(gap_cycles),
        .generated(av),
        .busy(busy),
        .done(done),
        .len_error(len_error),
        .packets_sent(packets_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst        = 1'b0;
        start      = 1'b0;
        packet_len = '0;
        seed       = '0;
        gap_cycles = '0;
        av.rdy     = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 128'(av.valid), 128'd0);
        chk("rst_sop", 128'(av.sop), 128'd0);
        chk("rst_eop", 128'(av.eop), 128'd0);
        chk("rst_data", av.data, 128'd0);
        chk("rst_empty", 128'(av.empty), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_len_error", 128'(len_error), 128'd0);
        chk("rst_packets", 128'(packets_sent), 128'd0);
        rst = 1'b1;
        tick();

        // Multi-beat packet: L=40, seed 0x10
        packet_len = 16'd40; seed = 8'h10; gap_cycles = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mb_b0_valid", 128'(av.valid), 128'd1);
        chk("mb_b0_sop", 128'(av.sop), 128'd1);
        chk("mb_b0_eop", 128'(av.eop), 128'd0);
        chk("mb_b0_busy", 128'(busy), 128'd1);
        chk("mb_b0_data", av.data, 128'h101112131415161718191A1B1C1D1E1F);
        chk("mb_b0_empty", 128'(av.empty), 128'd0);
        tick();
        chk("mb_b1_valid", 128'(av.valid), 128'd1);
        chk("mb_b1_sop", 128'(av.sop), 128'd0);
        chk("mb_b1_eop", 128'(av.eop), 128'd0);
        chk("mb_b1_data", av.data, 128'h202122232425262728292A2B2C2D2E2F);
        tick();
        chk("mb_b2_valid", 128'(av.valid), 128'd1);
        chk("mb_b2_eop", 128'(av.eop), 128'd1);
        chk("mb_b2_empty", 128'(av.empty), 128'd8);
        chk("mb_b2_data", av.data, 128'h30313233343536370000000000000000);
        chk("mb_b2_done", 128'(done), 128'd0);
        tick();
        chk("mb_end_valid", 128'(av.valid), 128'd0);
        chk("mb_end_done", 128'(done), 128'd1);
        chk("mb_end_packets", 128'(packets_sent), 128'd1);
        chk("mb_end_busy", 128'(busy), 128'd0);
        tick();
        chk("mb_done_pulse", 128'(done), 128'd0);

        // Single full beat: L=16, seed 0x00
        packet_len = 16'd16; seed = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("sb_sop", 128'(av.sop), 128'd1);
        chk("sb_eop", 128'(av.eop), 128'd1);
        chk("sb_empty", 128'(av.empty), 128'd0);
        chk("sb_data", av.data, 128'h000102030405060708090A0B0C0D0E0F);
        tick();
        chk("sb_busy_drop", 128'(busy), 128'd0);
        chk("sb_done", 128'(done), 128'd1);
        chk("sb_packets", 128'(packets_sent), 128'd2);
        chk("sb_valid_drop", 128'(av.valid), 128'd0);
        tick();

        // Backpressure and byte wrap: L=20, seed 0xF8, rdy 1,0,0,1
        packet_len = 16'd20; seed = 8'hF8; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_b0_sop", 128'(av.sop), 128'd1);
        chk("bp_b0_data", av.data, 128'hF8F9FAFBFCFDFEFF0001020304050607);
        tick();
        av.rdy = 1'b0;
        chk("bp_b1_data", av.data, 128'h08090A0B000000000000000000000000);
        chk("bp_b1_eop", 128'(av.eop), 128'd1);
        chk("bp_b1_empty", 128'(av.empty), 128'd12);
        chk("bp_b1_sop", 128'(av.sop), 128'd0);
        tick();
        chk("bp_hold1_valid", 128'(av.valid), 128'd1);
        chk("bp_hold1_data", av.data, 128'h08090A0B000000000000000000000000);
        chk("bp_hold1_eop", 128'(av.eop), 128'd1);
        chk("bp_hold1_empty", 128'(av.empty), 128'd12);
        tick();
        av.rdy = 1'b1;
        chk("bp_hold2_valid", 128'(av.valid), 128'd1);
        chk("bp_hold2_data", av.data, 128'h08090A0B000000000000000000000000);
        chk("bp_hold2_done", 128'(done), 128'd0);
        tick();
        chk("bp_end_valid", 128'(av.valid), 128'd0);
        chk("bp_end_done", 128'(done), 128'd1);
        chk("bp_end_packets", 128'(packets_sent), 128'd3);
        tick();

        // start held through SEND and GAP is not queued
        packet_len = 16'd32; seed = 8'h00; gap_cycles = 8'd2; start = 1'b1;
        tick();
        chk("ig_b0_sop", 128'(av.sop), 128'd1);
        tick();
        chk("ig_b1_sop", 128'(av.sop), 128'd0);
        chk("ig_b1_eop", 128'(av.eop), 128'd1);
        tick();
        chk("ig_gap1_busy", 128'(busy), 128'd1);
        chk("ig_gap1_valid", 128'(av.valid), 128'd0);
        tick();
        start = 1'b0;
        chk("ig_gap2_busy", 128'(busy), 128'd1);
        chk("ig_gap2_valid", 128'(av.valid), 128'd0);
        tick();
        chk("ig_idle_busy", 128'(busy), 128'd0);
        tick();
        chk("ig_idle_valid", 128'(av.valid), 128'd0);
        chk("ig_packets", 128'(packets_sent), 128'd4);

        // Zero-length start is rejected
        packet_len = 16'd0; gap_cycles = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("le_pulse", 128'(len_error), 128'd1);
        chk("le_valid", 128'(av.valid), 128'd0);
        chk("le_busy", 128'(busy), 128'd0);
        tick();
        chk("le_pulse_end", 128'(len_error), 128'd0);
        chk("le_valid2", 128'(av.valid), 128'd0);

        // Reset mid-packet
        packet_len = 16'd48; seed = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rm_b0_sop", 128'(av.sop), 128'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rm_valid", 128'(av.valid), 128'd0);
        chk("rm_sop", 128'(av.sop), 128'd0);
        chk("rm_eop", 128'(av.eop), 128'd0);
        chk("rm_data", av.data, 128'd0);
        chk("rm_empty", 128'(av.empty), 128'd0);
        chk("rm_busy", 128'(busy), 128'd0);
        chk("rm_done", 128'(done), 128'd0);
        chk("rm_packets", 128'(packets_sent), 128'd0);
        packet_len = 16'd16; seed = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rm_new_sop", 128'(av.sop), 128'd1);
        chk("rm_new_eop", 128'(av.eop), 128'd1);
        chk("rm_new_data", av.data, 128'h55565758595A5B5C5D5E5F6061626364);
        tick();
        chk("rm_new_packets", 128'(packets_sent), 128'd1);
        tick();

        // Gap timing: G=3, start held for two packets
        packet_len = 16'd16; seed = 8'h00; gap_cycles = 8'd3; start = 1'b1;
        tick();
        chk("gp_p1_sop", 128'(av.sop), 128'd1);
        chk("gp_p1_eop", 128'(av.eop), 128'd1);
        tick();
        chk("gp_done", 128'(done), 128'd1);
        chk("gp_busy1", 128'(busy), 128'd1);
        tick();
        chk("gp_busy2", 128'(busy), 128'd1);
        chk("gp_valid2", 128'(av.valid), 128'd0);
        tick();
        chk("gp_busy3", 128'(busy), 128'd1);
        tick();
        chk("gp_idle_busy", 128'(busy), 128'd0);
        chk("gp_idle_valid", 128'(av.valid), 128'd0);
        tick();
        start = 1'b0;
        chk("gp_p2_valid", 128'(av.valid), 128'd1);
        chk("gp_p2_sop", 128'(av.sop), 128'd1);
        tick();
        chk("gp_p2_done", 128'(done), 128'd1);
        chk("gp_packets", 128'(packets_sent), 128'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
